pc_fetch_sequencer: RTL and testbench

//  Sequences the 32-bit program counter and the instruction-memory fetch handshake.

---
 rtl/pc_fetch_sequencer_if.sv | 51 +++++
 rtl/pc_fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bundle: redirect inputs, imem handshake, IF-stage outputs.
// o_Misalign exists only when PC_MISALIGN_TRAP_EN is defined.
interface pc_fetch_sequencer_if #(
  parameter int N = 32
);
  logic         i_Stall;
  logic         i_Branch;
  logic [N-1:0] i_BranchTarget_dw;
  logic         i_Jump;
  logic [N-1:0] i_JumpTarget_dw;
  logic         o_ImemReq;
  logic         i_ImemAck;
  logic [N-1:0] o_PC_dw;
  logic [N-1:0] o_PCPlus4_dw;
  logic         o_InstrValid;
`ifdef PC_MISALIGN_TRAP_EN
  logic         o_Misalign;
`endif

  modport master (
    input  i_Stall,
    input  i_Branch,
    input  i_BranchTarget_dw,
    input  i_Jump,
    input  i_JumpTarget_dw,
    input  i_ImemAck,
    output o_ImemReq,
    output o_PC_dw,
    output o_PCPlus4_dw,
`ifdef PC_MISALIGN_TRAP_EN
    output o_Misalign,
`endif
    output o_InstrValid
  );

  modport slave (
    output i_Stall,
    output i_Branch,
    output i_BranchTarget_dw,
    output i_Jump,
    output i_JumpTarget_dw,
    output i_ImemAck,
    input  o_ImemReq,
    input  o_PC_dw,
    input  o_PCPlus4_dw,
`ifdef PC_MISALIGN_TRAP_EN
    input  o_Misalign,
`endif
    input  o_InstrValid
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer with single-outstanding imem fetch and delay-slot redirects.
// Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
  parameter int           N          = 32,
  parameter int           ADDR_W     = 20,
`ifdef PC_MISALIGN_TRAP_EN
  parameter logic [N-1:0] EXC_VECTOR = 32'h0000_0180,
`endif
  parameter logic [N-1:0] RESET_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  pc_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  function automatic logic [N-1:0] msk(
    input logic [N-1:0] a
  );
    logic [N-1:0] r;
    r = '0;
    r[ADDR_W-1:0] = a[ADDR_W-1:0];
    return r;
  endfunction

  state_t       state;
  logic [N-1:0] pc;
  logic [N-1:0] pcp4;
  logic         req;
  logic         valid;
  logic         pend_vld;
  logic [N-1:0] pend_pc;
  logic [N-1:0] pc_plus4;
  logic         redir;
  logic [N-1:0] tgt;
  logic [N-1:0] redir_pc;
  logic         redir_mis;
  logic         pend_mis;
  logic         mis;

  assign pc_plus4 = msk(pc + 32'd4);

  // Jump wins over branch when both fire together
  always_comb begin
    redir = bus.i_Jump | bus.i_Branch;
    tgt   = bus.i_Jump ? bus.i_JumpTarget_dw
                       : bus.i_BranchTarget_dw;
`ifdef PC_MISALIGN_TRAP_EN
    redir_mis = redir && (tgt[1:0] != 2'b00);
    redir_pc  = redir_mis ? msk(EXC_VECTOR)
                          : msk(tgt);
`else
    redir_mis = 1'b0;
    redir_pc  = msk({tgt[N-1:2], 2'b00});
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= msk(RESET_ADDR);
      pcp4     <= '0;
      req      <= 1'b0;
      valid    <= 1'b0;
      pend_vld <= 1'b0;
      pend_pc  <= '0;
      pend_mis <= 1'b0;
      mis      <= 1'b0;
    end else begin
      valid <= 1'b0;
      mis   <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (bus.i_ImemAck) begin
            valid    <= 1'b1;
            pcp4     <= pc_plus4;
            pend_vld <= 1'b0;
            pend_mis <= 1'b0;
            if (redir) begin
              pc  <= redir_pc;
              mis <= redir_mis;
            end else if (pend_vld) begin
              pc  <= pend_pc;
              mis <= pend_mis;
            end else begin
              pc <= pc_plus4;
            end
            if (bus.i_Stall) begin
              state <= HOLD;
              req   <= 1'b0;
            end
          end else if (redir) begin
            // Fetch in flight is the delay slot; redirect lands at its ack
            pend_vld <= 1'b1;
            pend_pc  <= redir_pc;
            pend_mis <= redir_mis;
          end
        end
        HOLD: begin
          if (redir) begin
            pc  <= redir_pc;
            mis <= redir_mis;
          end
          if (!bus.i_Stall) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_PC_dw      = pc;
  assign bus.o_PCPlus4_dw = pcp4;
  assign bus.o_ImemReq    = req;
  assign bus.o_InstrValid = valid;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.o_Misalign   = mis;
`endif

  logic unused_bits;
  assign unused_bits = ^{mis, pend_mis, redir_mis, tgt};

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer (default or PC_MISALIGN_TRAP_EN build).
// Outputs sampled 1 ns after each rising edge; inputs changed at the same point.
module tb_pc_fetch_sequencer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pc_fetch_sequencer_if #(.N(32)) bus ();

  pc_fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.i_Stall           = 1'b0;
    bus.i_Branch          = 1'b0;
    bus.i_Jump            = 1'b0;
    bus.i_ImemAck         = 1'b0;
    bus.i_BranchTarget_dw = '0;
    bus.i_JumpTarget_dw   = '0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    bus.i_Jump          = 1'b1;
    bus.i_JumpTarget_dw = t;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_in();
    reset = 1'b1;

    // 1: reset then fetch with ack every other cycle
    step(); step(); step();
    chk("rst_pc", bus.o_PC_dw, 32'h0);
    chk("rst_req", {31'd0, bus.o_ImemReq}, 32'd0);
    chk("rst_vld", {31'd0, bus.o_InstrValid}, 32'd0);
    chk("rst_pc4", bus.o_PCPlus4_dw, 32'h0);
    reset = 1'b0;
    step();
    chk("req_up", {31'd0, bus.o_ImemReq}, 32'd1);
    chk("pc0", bus.o_PC_dw, 32'h0);
    bus.i_ImemAck = 1'b1; step();
    chk("pc4", bus.o_PC_dw, 32'h4);
    chk("vld1", {31'd0, bus.o_InstrValid}, 32'd1);
    chk("pc4_p4", bus.o_PCPlus4_dw, 32'h4);
    bus.i_ImemAck = 1'b0; step();
    chk("vld_drop", {31'd0, bus.o_InstrValid}, 32'd0);
    chk("pc4_hold", bus.o_PC_dw, 32'h4);
    bus.i_ImemAck = 1'b1; step();
    chk("pc8", bus.o_PC_dw, 32'h8);
    bus.i_ImemAck = 1'b0; step();

    // 2: branch pending while fetching 0x8 (delay slot)
    bus.i_Branch = 1'b1;
    bus.i_BranchTarget_dw = 32'h100;
    step();
    chk("br_pend_pc", bus.o_PC_dw, 32'h8);
    bus.i_Branch = 1'b0;
    bus.i_ImemAck = 1'b1; step();
    chk("br_pc", bus.o_PC_dw, 32'h100);
    chk("br_p4", bus.o_PCPlus4_dw, 32'hC);
    idle_in(); step();
    bus.i_Branch = 1'b1;
    bus.i_BranchTarget_dw = 32'h300;
    do_jump(32'h200);
    bus.i_ImemAck = 1'b1; step();
    chk("jmp_prio", bus.o_PC_dw, 32'h200);
    chk("jmp_p4", bus.o_PCPlus4_dw, 32'h104);
    idle_in(); step();

    // 3: stall at ack, jump in HOLD
    do_jump(32'h10);
    bus.i_ImemAck = 1'b1; step();
    chk("pc10", bus.o_PC_dw, 32'h10);
    idle_in(); step();
    bus.i_Stall = 1'b1;
    bus.i_ImemAck = 1'b1; step();
    chk("stall_pc", bus.o_PC_dw, 32'h14);
    chk("stall_vld", {31'd0, bus.o_InstrValid}, 32'd1);
    chk("stall_req", {31'd0, bus.o_ImemReq}, 32'd0);
    step();
    chk("hold_ack_ign", bus.o_PC_dw, 32'h14);
    chk("hold_no_vld", {31'd0, bus.o_InstrValid}, 32'd0);
    bus.i_ImemAck = 1'b0;
    do_jump(32'h40); step();
    chk("hold_jmp", bus.o_PC_dw, 32'h40);
    chk("hold_req", {31'd0, bus.o_ImemReq}, 32'd0);
    idle_in(); step();
    chk("rel_req", {31'd0, bus.o_ImemReq}, 32'd1);
    chk("rel_pc", bus.o_PC_dw, 32'h40);

    // 4: address window wrap and masking
    do_jump(32'h000F_FFFC);
    bus.i_ImemAck = 1'b1; step();
    chk("pc_top", bus.o_PC_dw, 32'h000F_FFFC);
    bus.i_Jump = 1'b0; step();
    chk("wrap_pc", bus.o_PC_dw, 32'h0);
    chk("wrap_p4", bus.o_PCPlus4_dw, 32'h0);
    do_jump(32'hFFF0_0020); step();
    chk("mask_pc", bus.o_PC_dw, 32'h20);
    idle_in(); step();

    // pending overwritten by newer redirect
    bus.i_Branch = 1'b1;
    bus.i_BranchTarget_dw = 32'h300; step();
    bus.i_Branch = 1'b0;
    do_jump(32'h400); step();
    chk("pend_hold", bus.o_PC_dw, 32'h20);
    idle_in();
    bus.i_ImemAck = 1'b1; step();
    chk("pend_new", bus.o_PC_dw, 32'h400);
    bus.i_ImemAck = 1'b0; step();

    // 5: reset during fetch with ack in same cycle
    reset = 1'b1;
    bus.i_ImemAck = 1'b1; step();
    chk("rst_mid_pc", bus.o_PC_dw, 32'h0);
    chk("rst_mid_vld", {31'd0, bus.o_InstrValid}, 32'd0);
    chk("rst_mid_req", {31'd0, bus.o_ImemReq}, 32'd0);
    reset = 1'b0;
    bus.i_ImemAck = 1'b0; step();
    chk("rst_rereq", {31'd0, bus.o_ImemReq}, 32'd1);

    // 6: misaligned jump target
    do_jump(32'h102);
    bus.i_ImemAck = 1'b1; step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", bus.o_PC_dw, 32'h180);
    chk("mis_pulse", {31'd0, bus.o_Misalign}, 32'd1);
`else
    chk("mis_pc", bus.o_PC_dw, 32'h100);
`endif
    idle_in(); step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_drop", {31'd0, bus.o_Misalign}, 32'd0);
`endif
    chk("end_vld", {31'd0, bus.o_InstrValid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
